// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Purpose  : Drives every input vector of a small combinational lab DUT and
//            checks its outputs against an expected truth table. The optional
//            STOP_ON_ERR_EN macro ends the sweep at the first mismatch.
// Revision : 1.0
// ============================================================================
module truth_table_sweeper #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int HOLD  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N_OUT*(2**N_IN)-1:0] exp_table,
  input  logic [N_OUT-1:0]           dut_out,
  output logic [N_IN-1:0]            dut_in,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_IN:0]              err_count,
  output logic [N_IN-1:0]            first_err_idx,
  output logic                       err_seen
);

  localparam int              c_NVEC      = 2**N_IN;
  localparam logic [15:0]     c_HOLD_LAST = 16'(HOLD - 1);
  localparam logic [N_IN-1:0] c_IDX_LAST  = '1;
  localparam logic [N_IN:0]   c_ERR_MAX   = {1'b1, {N_IN{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_hold_cnt;
  logic [N_IN-1:0]  r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_err_seen;
  logic [N_IN:0]    r_err_count;
  logic [N_IN-1:0]  r_first_err_idx;
  logic [N_OUT-1:0] w_exp_arr [c_NVEC];
  logic             w_sample;
  logic             w_mis;
  logic             w_stop;
  logic             w_finish;

  generate
    for (genvar g = 0; g < c_NVEC; g++) begin : g_exp_slice
      assign w_exp_arr[g] = exp_table[g*N_OUT +: N_OUT];
    end
  endgenerate

  always_comb begin
    w_sample    = (r_state == S_DRIVE) && (r_hold_cnt == c_HOLD_LAST);
    w_mis       = w_sample && (dut_out != w_exp_arr[r_idx]);
`ifdef STOP_ON_ERR_EN
    w_stop      = w_mis;
`else
    w_stop      = 1'b0;
`endif
    w_finish    = w_sample && ((r_idx == c_IDX_LAST) || w_stop);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start)    w_state_nxt = S_DRIVE;
      S_DRIVE:        if (w_finish) w_state_nxt = S_DONE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx           <= '0;
      r_hold_cnt      <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      r_err_seen      <= 1'b0;
    end else if ((r_state != S_DRIVE) && start) begin
      r_idx           <= '0;
      r_hold_cnt      <= '0;
      r_busy          <= 1'b1;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      r_err_seen      <= 1'b0;
    end else if (r_state == S_DRIVE) begin
      if (w_sample) begin
        r_hold_cnt <= '0;
        if (w_mis) begin
          if (r_err_count != c_ERR_MAX) r_err_count <= r_err_count + 1'b1;
          if (!r_err_seen) begin
            r_first_err_idx <= r_idx;
            r_err_seen      <= 1'b1;
          end
        end
        if (w_finish) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= !(r_err_seen || w_mis);
          // An early stop leaves the failing vector on the pins for probing.
          if (!w_stop) r_idx <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign dut_in        = r_idx;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign first_err_idx = r_first_err_idx;
  assign err_seen      = r_err_seen;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sweeper
// Purpose  : Self-checking bench for truth_table_sweeper (HOLD=4 and HOLD=1).
// Revision : 1.0
// ============================================================================
module tb_truth_table_sweeper;

  localparam int NI = 3;
  localparam int NO = 2;
  localparam int NV = 8;
`ifdef STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [2];
  logic [15:0] exp_tbl [2];
  logic [1:0]  dut_out [2];
  logic [2:0]  dut_in [2];
  logic        busy [2];
  logic        done [2];
  logic        pass [2];
  logic [3:0]  err_count [2];
  logic [2:0]  first_err_idx [2];
  logic        err_seen [2];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // Lab circuit under test: y = {a&b | c, a^b^c}
  function automatic logic [1:0] golden(input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return {(a & b) | c, a ^ b ^ c};
  endfunction

  function automatic logic [15:0] golden_table();
    logic [15:0] t;
    for (int k = 0; k < NV; k++) t[k*2 +: 2] = golden(3'(k));
    return t;
  endfunction

  assign dut_out[0] = golden(dut_in[0]);
  assign dut_out[1] = golden(dut_in[1]);

  truth_table_sweeper #(.N_IN(NI), .N_OUT(NO), .HOLD(4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .exp_table(exp_tbl[0]),
    .dut_out(dut_out[0]), .dut_in(dut_in[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err_count[0]), .first_err_idx(first_err_idx[0]),
    .err_seen(err_seen[0])
  );

  truth_table_sweeper #(.N_IN(NI), .N_OUT(NO), .HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .exp_table(exp_tbl[1]),
    .dut_out(dut_out[1]), .dut_in(dut_in[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err_count[1]), .first_err_idx(first_err_idx[1]),
    .err_seen(err_seen[1])
  );

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic check_idle(input int h);
    check("idle_in",    dut_in[h], 0);
    check("idle_busy",  busy[h], 0);
    check("idle_done",  done[h], 0);
    check("idle_pass",  pass[h], 0);
    check("idle_cnt",   err_count[h], 0);
    check("idle_first", first_err_idx[h], 0);
    check("idle_seen",  err_seen[h], 0);
  endtask

  // Full sweep of instance h against table tbl; the model is derived only
  // from which table entries disagree with the lab circuit.
  task automatic sweep(input int h, input logic [15:0] tbl, input int pulse_at,
                       input bit keep_start);
    int hv, nerr, first, jend, exp_cnt, exp_in, n;
    hv = (h == 0) ? 4 : 1;
    nerr = 0;
    first = -1;
    for (int k = 0; k < NV; k++) begin
      if (tbl[k*2 +: 2] != golden(3'(k))) begin
        nerr++;
        if (first < 0) first = k;
      end
    end
    if (STOP && nerr > 0) begin
      jend = (first + 1) * hv; exp_cnt = 1; exp_in = first;
    end else begin
      jend = NV * hv; exp_cnt = nerr; exp_in = 0;
    end
    @(negedge clk);
    exp_tbl[h] = tbl;
    start[h] = 1'b1;
    @(posedge clk); #1;
    start[h] = 1'b0;
    check("e0_busy", busy[h], 1);
    check("e0_done", done[h], 0);
    check("e0_cnt",  err_count[h], 0);
    check("e0_seen", err_seen[h], 0);
    check("e0_in",   dut_in[h], 0);
    for (int j = 1; j <= jend; j++) begin
      @(posedge clk); #1;
      start[h] = (j == pulse_at) && (j < jend);
      if (j < jend) begin
        check("trace_in",   dut_in[h], j / hv);
        check("trace_busy", busy[h], 1);
        check("trace_done", done[h], 0);
      end else begin
        check("end_done",  done[h], 1);
        check("end_busy",  busy[h], 0);
        check("end_pass",  pass[h], (nerr == 0) ? 1 : 0);
        check("end_cnt",   err_count[h], exp_cnt);
        check("end_first", first_err_idx[h], (nerr > 0) ? first : 0);
        check("end_seen",  err_seen[h], (nerr > 0) ? 1 : 0);
        check("end_in",    dut_in[h], exp_in);
      end
    end
    if (keep_start) begin
      start[h] = 1'b1;
      @(posedge clk); #1;
      start[h] = 1'b0;
      check("restart_done", done[h], 0);
      check("restart_busy", busy[h], 1);
      check("restart_in",   dut_in[h], 0);
      check("restart_cnt",  err_count[h], 0);
      n = 0;
      while (!done[h] && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check("restart_finish", done[h], 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] tbl;
    int h, p;
    start[0] = 1'b0;
    start[1] = 1'b0;
    exp_tbl[0] = golden_table();
    exp_tbl[1] = golden_table();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0);
    check_idle(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct table, single Y1 fault at vector 5, fully inverted table twice
    sweep(0, golden_table(), 0, 1'b0);
    sweep(0, golden_table() ^ (16'h0001 << 11), 0, 1'b0);
    sweep(0, ~golden_table(), 0, 1'b0);
    sweep(0, ~golden_table(), 0, 1'b0);
    // Fault at vector 3 (early-stop case when the macro is set)
    sweep(0, golden_table() ^ (16'h0001 << 6), 0, 1'b0);
    // start pulse mid-sweep is ignored
    sweep(0, golden_table(), 10, 1'b0);

    // HOLD=1: one vector per cycle, then start held high in DONE
    sweep(1, golden_table(), 0, 1'b1);
    sweep(1, ~golden_table(), 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      h = int'($urandom_range(0, 1));
      p = int'($urandom_range(0, 7));
      tbl = golden_table() ^ 16'($urandom & $urandom & $urandom);
      sweep(h, tbl, p, 1'b0);
    end

    // Reset in the middle of a sweep aborts it
    @(negedge clk);
    exp_tbl[0] = ~golden_table();
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle(0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_idle(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
